floor_controller: RTL and testbench
===================================

FLOOR_CONTROLLER -- requirements
Module: floor_controller

Interface
REQ-001 SHALL have parameter ST_FLOOR, default 2'b00, encoding of floor 1.
REQ-002 SHALL have parameter ND_FLOOR, default 2'b01, encoding of floor 2.
REQ-003 SHALL have parameter RD_FLOOR, default 2'b10, encoding of floor 3.
REQ-004 SHALL have parameter TRAVEL_CYCLES, default 8, clocks per one-floor move (>=1).
REQ-005 SHALL have parameter DOOR_CYCLES, default 4, dwell clocks after door opens (>=1).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 st_button / nd_button / rd_button  input  1 each  floor call buttons, level, already synchronous to clk.
REQ-009 open_door  input  1  door-open indication from the downstream door_status stage.
REQ-010 state  output  2  current car floor (ST_FLOOR/ND_FLOOR/RD_FLOOR only).
REQ-011 st_led / nd_led / rd_led  output  1 each  registered pending-call flags per floor.
REQ-012 moving  output  1  high while car is between floors.
REQ-013 dir_up  output  1  current/last travel direction, 1 = up.

Function
REQ-014 Button high in any cycle SHALL set its led on the next edge; led stays set until cleared per REQ-020.
REQ-015 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR; all registered outputs driven from state/regs only.
REQ-016 IDLE: led at current floor set -> DOOR; else call ahead in dir_up direction -> continue that way; else call behind -> reverse (update dir_up) and move; else stay IDLE.
REQ-017 MOVE_x SHALL assert moving and count TRAVEL_CYCLES clocks, then step state one floor (ST<->ND<->RD) in the same edge the counter expires.
REQ-018 On arrival: led at new floor set -> DOOR; else call still ahead -> restart travel counter in same direction; else -> IDLE.
REQ-019 state SHALL never step below ST_FLOOR or above RD_FLOOR; no call ahead at an end floor forces re-evaluation in IDLE.
REQ-020 DOOR: wait for open_door=1; on that edge clear led of current floor and start dwell counter; after DOOR_CYCLES further clocks -> IDLE.
REQ-021 Simultaneous button and clear for the current floor in DOOR: clear SHALL win; buttons for other floors still set.
REQ-022 Button for current floor while in IDLE SHALL go DOOR without moving (latency: led set edge N, DOOR at edge N+1).
REQ-023 Button for a floor being passed mid-travel SHALL be serviced on arrival at that floor if still in travel direction.
REQ-024 open_door while not in DOOR SHALL be ignored.
REQ-025 Counters SHALL be sized $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1) bits, no wrap.

Reset
REQ-026 rst SHALL, on the next edge, force FSM=IDLE, state=ST_FLOOR, all leds=0, moving=0, dir_up=1, counters=0.
REQ-027 rst mid-travel or mid-dwell SHALL abandon the operation immediately; button inputs sampled while rst high are discarded.

Structure
REQ-028 Floor encodings, FSM state enum and default cycle counts SHALL live in shared package elevator_pkg.
REQ-029 The call-latch logic (three set/clear flops) SHALL be one sub-module call_register; FSM and counters stay in floor_controller.

Verification
REQ-030 Reset, no buttons, 20 clocks -> state=00, leds=000, moving=0, dir_up=1 throughout.
REQ-031 At ST_FLOOR press rd_button 1 clock -> rd_led=1 next edge; state=01 after 8 travel clocks, state=10 after 16; DOOR entered; open_door pulse clears rd_led; IDLE 4 clocks later.
REQ-032 At ND_FLOOR idle, press st_button and rd_button same cycle with dir_up=1 -> goes to RD first, then reverses (dir_up=0) to ST.
REQ-033 In DOOR at ND_FLOOR, hold nd_button across open_door edge -> nd_led=0 after that edge.
REQ-034 Moving up from ST to RD, press nd_button during first 3 travel clocks -> car stops at ND (DOOR) before continuing to RD.
REQ-035 Assert rst during MOVE_UP at travel count 5 -> next edge state=00, moving=0, leds=000.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared constants for the three-floor elevator controller:
// floor encodings, FSM states, default timings and call-lookup helpers.
package elevator_pkg;

  localparam logic [1:0] FLOOR1_ENC = 2'b00;
  localparam logic [1:0] FLOOR2_ENC = 2'b01;
  localparam logic [1:0] FLOOR3_ENC = 2'b10;

  localparam logic [1:0] P_ST = 2'd0;
  localparam logic [1:0] P_ND = 2'd1;
  localparam logic [1:0] P_RD = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;

  localparam int TRAVEL_CYCLES_DEF = 8;
  localparam int DOOR_CYCLES_DEF   = 4;

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Pending call at position p (0=bottom, 2=top).
  function automatic logic at_floor(logic [2:0] l, logic [1:0] p);
    case (p)
      P_ST:    return l[0];
      P_ND:    return l[1];
      default: return l[2];
    endcase
  endfunction

  // Any pending call strictly beyond position p in the given direction.
  function automatic logic call_ahead(logic [2:0] l, logic [1:0] p,
                                      logic up);
    if (up) begin
      case (p)
        P_ST:    return |l[2:1];
        P_ND:    return l[2];
        default: return 1'b0;
      endcase
    end else begin
      case (p)
        P_RD:    return |l[1:0];
        P_ND:    return l[0];
        default: return 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/floor_controller_call_register.sv
// Pending-call latches, one per floor (bit 0 = bottom floor).
// A clear in the same cycle as a press wins.
module call_register
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic [2:0] clr,
  output logic [2:0] led
);

  logic [2:0] led_q;
  logic [2:0] led_d;

  // Set on press, clear on service; clear has priority.
  always_comb begin
    led_d = (led_q | btn) & ~clr;
  end

  // Call flags; presses during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: rtl/floor_controller.sv
// Three-floor elevator controller: call latches, travel/door FSM
// with cycle counters for inter-floor travel and door dwell.
module floor_controller
  import elevator_pkg::*;
#(
  parameter logic [1:0] ST_FLOOR      = FLOOR1_ENC,
  parameter logic [1:0] ND_FLOOR      = FLOOR2_ENC,
  parameter logic [1:0] RD_FLOOR      = FLOOR3_ENC,
  parameter int         TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int         DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st_button,
  input  logic       nd_button,
  input  logic       rd_button,
  input  logic       open_door,
  output logic [1:0] state,
  output logic       st_led,
  output logic       nd_led,
  output logic       rd_led,
  output logic       moving,
  output logic       dir_up
);

  localparam int CW =
    $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [1:0]    fsm_q, fsm_d;
  logic [1:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dwell_q, dwell_d;
  logic [2:0]    led;
  logic [2:0]    clr;
  logic [1:0]    nxt;

  call_register u_calls (
    .clk (clk),
    .rst (rst),
    .btn ({rd_button, nd_button, st_button}),
    .clr (clr),
    .led (led)
  );

  // Next-state logic: dispatch from idle, travel timing, door handling.
  always_comb begin
    fsm_d   = fsm_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    clr     = 3'b000;
    nxt     = pos_q;
    case (fsm_q)
      S_IDLE: begin
        cnt_d   = '0;
        dwell_d = 1'b0;
        if (at_floor(led, pos_q)) begin
          fsm_d = S_DOOR;
        end else if (call_ahead(led, pos_q, dir_q)) begin
          fsm_d = dir_q ? S_UP : S_DOWN;
        end else if (call_ahead(led, pos_q, !dir_q)) begin
          dir_d = !dir_q;
          fsm_d = dir_q ? S_DOWN : S_UP;
        end
      end
      S_UP, S_DOWN: begin
        nxt = (fsm_q == S_UP) ? pos_q + 2'd1 : pos_q - 2'd1;
        // An end floor has nothing beyond it; fall back to idle.
        if ((fsm_q == S_UP && pos_q == P_RD) ||
            (fsm_q == S_DOWN && pos_q == P_ST)) begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end else if (cnt_q == T_LAST) begin
          pos_d = nxt;
          cnt_d = '0;
          if (at_floor(led, nxt)) begin
            fsm_d   = S_DOOR;
            dwell_d = 1'b0;
          end else if (!call_ahead(led, nxt, fsm_q == S_UP)) begin
            fsm_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        if (!dwell_q) begin
          if (open_door) begin
            clr     = 3'b001 << pos_q;
            dwell_d = 1'b1;
            cnt_d   = '0;
          end
        end else if (cnt_q == D_LAST) begin
          fsm_d   = S_IDLE;
          dwell_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  // FSM, position, direction and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      pos_q   <= P_ST;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      dwell_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    case (pos_q)
      P_ST:    state = ST_FLOOR;
      P_ND:    state = ND_FLOOR;
      default: state = RD_FLOOR;
    endcase
  end

  assign moving = (fsm_q == S_UP) || (fsm_q == S_DOWN);
  assign dir_up = dir_q;
  assign st_led = led[0];
  assign nd_led = led[1];
  assign rd_led = led[2];

endmodule

// File: tb/tb_floor_controller.sv
// Directed scoreboard bench for floor_controller.
// Observed vector: {state, rd_led, nd_led, st_led, moving, dir_up}.
module tb_floor_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st_button = 1'b0;
  logic       nd_button = 1'b0;
  logic       rd_button = 1'b0;
  logic       open_door = 1'b0;
  logic [1:0] state;
  logic       st_led, nd_led, rd_led, moving, dir_up;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } item_t;

  item_t sb[$];

  floor_controller dut (
    .clk       (clk),
    .rst       (rst),
    .st_button (st_button),
    .nd_button (nd_button),
    .rd_button (rd_button),
    .open_door (open_door),
    .state     (state),
    .st_led    (st_led),
    .nd_led    (nd_led),
    .rd_led    (rd_led),
    .moving    (moving),
    .dir_up    (dir_up)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {state, rd_led, nd_led, st_led, moving, dir_up};

  function automatic logic [6:0] ex(logic [1:0] s, logic [2:0] l,
                                    logic m, logic d);
    return {s, l, m, d};
  endfunction

  // Queue the expectation, advance n edges, then pop and compare.
  task automatic step(input string tag, input int n,
                      input logic [6:0] e);
    item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    it = sb.pop_front();
    n_cmp++;
    assert (obs === it.exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
    end
  endtask

  // Open-door pulse then the full dwell back to idle.
  task automatic door(input string tag, input logic [6:0] e);
    open_door = 1'b1;
    step({tag, "_clr"}, 1, e);
    open_door = 1'b0;
    step({tag, "_dwell"}, 4, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    step("reset", 1, ex(2'b00, 3'b000, 0, 1));
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      step("idle20", 1, ex(2'b00, 3'b000, 0, 1));

    // Bottom to top, door cycle, dwell length observed via next move.
    rd_button = 1'b1;
    step("rd_set", 1, ex(2'b00, 3'b100, 0, 1));
    rd_button = 1'b0;
    step("up_start", 1, ex(2'b00, 3'b100, 1, 1));
    step("pre_nd", 7, ex(2'b00, 3'b100, 1, 1));
    step("at_nd", 1, ex(2'b01, 3'b100, 1, 1));
    step("pre_rd", 7, ex(2'b01, 3'b100, 1, 1));
    step("at_rd", 1, ex(2'b10, 3'b100, 0, 1));
    step("door_wait", 2, ex(2'b10, 3'b100, 0, 1));
    open_door = 1'b1;
    step("rd_clr", 1, ex(2'b10, 3'b000, 0, 1));
    open_door = 1'b0;
    st_button = 1'b1;
    step("st_in_dwell", 1, ex(2'b10, 3'b001, 0, 1));
    st_button = 1'b0;
    step("dwell_end", 3, ex(2'b10, 3'b001, 0, 1));
    step("rev_down", 1, ex(2'b10, 3'b001, 1, 0));
    open_door = 1'b1;
    step("open_ignored", 3, ex(2'b10, 3'b001, 1, 0));
    open_door = 1'b0;
    step("dn_nd", 5, ex(2'b01, 3'b001, 1, 0));
    step("dn_st", 8, ex(2'b00, 3'b001, 0, 0));
    door("st_door", ex(2'b00, 3'b000, 0, 0));

    // Current-floor call in idle opens the door without moving.
    st_button = 1'b1;
    step("here_set", 1, ex(2'b00, 3'b001, 0, 0));
    st_button = 1'b0;
    step("here_nomove", 2, ex(2'b00, 3'b001, 0, 0));
    door("here_door", ex(2'b00, 3'b000, 0, 0));

    // To ND, then simultaneous ST and RD calls with dir_up=1.
    nd_button = 1'b1;
    step("nd_set", 1, ex(2'b00, 3'b010, 0, 0));
    nd_button = 1'b0;
    step("rev_up", 1, ex(2'b00, 3'b010, 1, 1));
    step("arr_nd", 8, ex(2'b01, 3'b010, 0, 1));
    door("nd_door", ex(2'b01, 3'b000, 0, 1));
    st_button = 1'b1;
    rd_button = 1'b1;
    step("both_set", 1, ex(2'b01, 3'b101, 0, 1));
    st_button = 1'b0;
    rd_button = 1'b0;
    step("up_first", 1, ex(2'b01, 3'b101, 1, 1));
    step("arr_rd", 8, ex(2'b10, 3'b101, 0, 1));
    door("rd_door", ex(2'b10, 3'b001, 0, 1));
    step("then_down", 1, ex(2'b10, 3'b001, 1, 0));
    step("pass_nd", 8, ex(2'b01, 3'b001, 1, 0));
    step("arr_st", 8, ex(2'b00, 3'b001, 0, 0));
    door("st_door2", ex(2'b00, 3'b000, 0, 0));

    // Clear beats a held press at the door floor; other floors latch.
    nd_button = 1'b1;
    step("nd_set2", 1, ex(2'b00, 3'b010, 0, 0));
    nd_button = 1'b0;
    step("up_nd2", 1, ex(2'b00, 3'b010, 1, 1));
    step("arr_nd2", 8, ex(2'b01, 3'b010, 0, 1));
    step("nd_wait", 1, ex(2'b01, 3'b010, 0, 1));
    nd_button = 1'b1;
    rd_button = 1'b1;
    open_door = 1'b1;
    step("clr_wins", 1, ex(2'b01, 3'b100, 0, 1));
    nd_button = 1'b0;
    rd_button = 1'b0;
    open_door = 1'b0;
    step("dwell_nd", 4, ex(2'b01, 3'b100, 0, 1));
    step("up_rd3", 1, ex(2'b01, 3'b100, 1, 1));
    step("arr_rd3", 8, ex(2'b10, 3'b100, 0, 1));
    door("rd_door3", ex(2'b10, 3'b000, 0, 1));

    // Back to ST, then an ND call raised during the ST->RD trip.
    st_button = 1'b1;
    step("st_set4", 1, ex(2'b10, 3'b001, 0, 1));
    st_button = 1'b0;
    step("down4", 1, ex(2'b10, 3'b001, 1, 0));
    step("pass_nd4", 8, ex(2'b01, 3'b001, 1, 0));
    step("arr_st4", 8, ex(2'b00, 3'b001, 0, 0));
    door("st_door4", ex(2'b00, 3'b000, 0, 0));
    rd_button = 1'b1;
    step("rd_set5", 1, ex(2'b00, 3'b100, 0, 0));
    rd_button = 1'b0;
    step("up5", 1, ex(2'b00, 3'b100, 1, 1));
    nd_button = 1'b1;
    step("nd_mid", 1, ex(2'b00, 3'b110, 1, 1));
    nd_button = 1'b0;
    step("stop_nd", 7, ex(2'b01, 3'b110, 0, 1));
    door("nd_door5", ex(2'b01, 3'b100, 0, 1));
    step("resume_up", 1, ex(2'b01, 3'b100, 1, 1));
    step("arr_rd5", 8, ex(2'b10, 3'b100, 0, 1));
    door("rd_door5", ex(2'b10, 3'b000, 0, 1));

    // Reset from the top floor, then reset mid-travel at count 5.
    rst = 1'b1;
    step("rst_top", 1, ex(2'b00, 3'b000, 0, 1));
    rst = 1'b0;
    rd_button = 1'b1;
    step("rd_set6", 1, ex(2'b00, 3'b100, 0, 1));
    rd_button = 1'b0;
    step("up6", 1, ex(2'b00, 3'b100, 1, 1));
    step("cnt5", 5, ex(2'b00, 3'b100, 1, 1));
    rst = 1'b1;
    st_button = 1'b1;
    step("rst_mid", 1, ex(2'b00, 3'b000, 0, 1));
    rst = 1'b0;
    st_button = 1'b0;
    step("btn_discard", 3, ex(2'b00, 3'b000, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
